counter_cmd_gen: RTL and testbench
==================================

Name: counter_cmd_gen

Overview:
- Upstream command stage for the 4-bit up/clear counter.
- Takes two raw, bouncing, asynchronous pushbutton levels (increment and clear) and turns them into clean, single-cycle, mutually exclusive command pulses: INR, CLR, DEC.
- Adds hold-to-auto-repeat on increment, and chord detection (both buttons pressed) that issues a decrement command.

Parameters:
- DB_CYCLES, 4: consecutive stable synchronized samples required to accept a level change on either button; legal range 2..255.
- RPT_DELAY, 16: cycles the increment button must stay held after its accepted press before the first repeat pulse; legal range 2..255.
- RPT_PERIOD, 4: cycles between successive repeat pulses; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_inc  input  1  raw increment button, active-high, asynchronous, may bounce.
- btn_clr  input  1  raw clear button, active-high, asynchronous, may bounce.
- INR  output  1  one-cycle increment command.
- CLR  output  1  one-cycle clear command.
- DEC  output  1  one-cycle decrement command (chord).
- inc_lvl  output  1  debounced increment level.
- clr_lvl  output  1  debounced clear level.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release by the flops themselves):
  - All outputs are 0.
  - Synchronizers, debounced levels and counters are cleared.
  - FSM goes to IDLE.
  - Reset mid-press: no pulse after release of reset until a fresh accepted press edge.
- Synchronizer:
  - Each btn_* passes through two flops before any other use.
  - A raw change reaches the debouncer 2 cycles later.
- Debouncer, per button:
  - An 8-bit stable counter runs while the synchronized sample differs from the debounced level; it resets to 0 on any sample equal to the level.
  - When the counter reaches DB_CYCLES, the level toggles and the counter clears.
  - Glitches shorter than DB_CYCLES are rejected.
  - inc_lvl and clr_lvl are registered.
- Press edges: rise_inc and rise_clr are asserted for the cycle in which the respective level goes 0->1.
- Command arbitration (registered, 1 cycle after the level change; INR, CLR and DEC are never high together):
  - rise_inc and rise_clr in the same cycle -> DEC.
  - rise_inc while clr_lvl already 1 -> DEC.
  - rise_clr while inc_lvl already 1 -> DEC.
  - rise_clr alone -> CLR.
  - rise_inc alone -> INR.
  - Release edges produce no command.
- Auto-repeat FSM, states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on an accepted INR; an 8-bit hold counter loads 0.
  - HOLD: the counter increments each cycle. When it reaches RPT_DELAY-1 the block emits INR, reloads the counter to 0 and moves to REPEAT.
  - REPEAT: the counter increments. At RPT_PERIOD-1 the block emits INR and reloads to 0.
  - HOLD or REPEAT -> IDLE, with no pulse that cycle, when inc_lvl falls or clr_lvl rises.
  - A DEC chord forces IDLE.
  - Repeat never fires while clr_lvl is 1.
- Simultaneous events: a chord or clear edge in the same cycle as a due repeat pulse gives that edge's command (DEC or CLR) only; the repeat pulse is dropped.
- Latency from a clean raw press to the command pulse: 2 (sync) + DB_CYCLES (debounce) + 1 (output register) cycles; 7 at defaults.

Test Plan:
- Reset, then clean btn_inc 0->1 held 30 cycles at defaults -> INR high for exactly 1 cycle, 7 cycles after the edge. First repeat follows 16 cycles after the first pulse, then every 4 cycles. Release -> no further INR after inc_lvl falls.
- btn_clr with bounce (toggles at 1-, 2- and 3-cycle spacing) then stable high -> exactly one CLR pulse; clr_lvl rises once; no INR or DEC.
- btn_inc and btn_clr rise on the same clk edge -> one DEC pulse, no INR or CLR. Hold both 40 cycles -> no repeat pulses.
- btn_inc held into REPEAT, then btn_clr pressed -> DEC (the clear edge sees inc_lvl=1), FSM to IDLE, INR stops.
- btn_inc held, rst_n pulsed low for 3 cycles mid-REPEAT -> all outputs 0 immediately. After release, no INR until btn_inc is released and pressed again.
- 2-cycle glitches on btn_inc every 10 cycles for 100 cycles -> inc_lvl stays 0, zero pulses on all command outputs.

Source files
------------

// File: rtl/counter_cmd_gen.sv
// Pushbutton command front end: synchronize and debounce two buttons, then issue
// one-cycle INR / CLR / DEC pulses with hold-to-repeat on increment.

module counter_cmd_gen_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic lvl,
  output logic rise
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic [1:0] vld;
  logic [7:0] cnt;
  logic       lvl_q;
  logic       arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      vld   <= 2'b00;
      cnt   <= 8'd0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      arm   <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      vld   <= {vld[0], 1'b1};
      lvl_q <= lvl;
      if (s2 != lvl) begin
        if (cnt == DB_LAST) begin
          lvl <= ~lvl;
          cnt <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
      // A button held through reset must be seen released before its edges count.
      if (vld[1] && !s2 && !lvl) begin
        arm <= 1'b1;
      end
    end
  end

  assign rise = lvl & ~lvl_q & arm;

endmodule

// state  | meaning
// IDLE   | no repeat pending; waiting for an accepted increment press
// HOLD   | increment held, counting the initial repeat delay
// REPEAT | increment still held, issuing a pulse every repeat period
module counter_cmd_gen #(
  parameter int DB_CYCLES  = 4,
  parameter int RPT_DELAY  = 16,
  parameter int RPT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc,
  input  logic btn_clr,
  output logic INR,
  output logic CLR,
  output logic DEC,
  output logic inc_lvl,
  output logic clr_lvl
);

  localparam logic [7:0] DLY_LAST = 8'(RPT_DELAY - 1);
  localparam logic [7:0] PER_LAST = 8'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t     state;
  logic [7:0] hold_cnt;
  logic       rise_inc;
  logic       rise_clr;
  logic       inc_ev;
  logic       clr_ev;
  logic       dec_ev;
  logic       stop;

  counter_cmd_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .lvl   (inc_lvl),
    .rise  (rise_inc)
  );

  counter_cmd_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .lvl   (clr_lvl),
    .rise  (rise_clr)
  );

  // Any press edge while the other button is down is a chord.
  assign dec_ev = (rise_inc & clr_lvl) | (rise_clr & inc_lvl);
  assign clr_ev = rise_clr & ~inc_lvl;
  assign inc_ev = rise_inc & ~clr_lvl;
  assign stop   = dec_ev | ~inc_lvl | clr_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      INR      <= 1'b0;
      CLR      <= 1'b0;
      DEC      <= 1'b0;
    end else begin
      INR <= inc_ev;
      CLR <= clr_ev;
      DEC <= dec_ev;
      case (state)
        IDLE: begin
          if (inc_ev) begin
            state    <= HOLD;
            hold_cnt <= 8'd0;
          end
        end
        HOLD: begin
          if (stop) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
          end else if (hold_cnt == DLY_LAST) begin
            INR      <= 1'b1;
            hold_cnt <= 8'd0;
            state    <= REPEAT;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        REPEAT: begin
          if (stop) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
          end else if (hold_cnt == PER_LAST) begin
            INR      <= 1'b1;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_gen.sv
// Directed bench for counter_cmd_gen at default parameters; pulse times are
// recorded by cycle number and compared against hand-derived schedules.

module tb_counter_cmd_gen;

  logic clk;
  logic rst_n;
  logic btn_inc;
  logic btn_clr;
  logic INR;
  logic CLR;
  logic DEC;
  logic inc_lvl;
  logic clr_lvl;

  int tests;
  int fails;
  int cyc;
  int inr_q[$];
  int clr_q[$];
  int dec_q[$];
  int n_clr_rise;
  int n_inc_hi;
  int excl_err;
  logic clr_lvl_prev;

  counter_cmd_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_inc (btn_inc),
    .btn_clr (btn_clr),
    .INR     (INR),
    .CLR     (CLR),
    .DEC     (DEC),
    .inc_lvl (inc_lvl),
    .clr_lvl (clr_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse recorder, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (INR === 1'b1) inr_q.push_back(cyc);
    if (CLR === 1'b1) clr_q.push_back(cyc);
    if (DEC === 1'b1) dec_q.push_back(cyc);
    if ((32'(INR) + 32'(CLR) + 32'(DEC)) > 1) excl_err = excl_err + 1;
    if (clr_lvl === 1'b1 && clr_lvl_prev !== 1'b1) n_clr_rise = n_clr_rise + 1;
    if (inc_lvl === 1'b1) n_inc_hi = n_inc_hi + 1;
    clr_lvl_prev = clr_lvl;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    inr_q.delete();
    clr_q.delete();
    dec_q.delete();
    n_clr_rise = 0;
    n_inc_hi   = 0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    wait_cycles(3);
    tests++; if ({INR, CLR, DEC} !== 3'b000) begin fails++; $display("FAIL reset_cmds got %b want 000", {INR, CLR, DEC}); end
    tests++; if ({inc_lvl, clr_lvl} !== 2'b00) begin fails++; $display("FAIL reset_lvls got %b want 00", {inc_lvl, clr_lvl}); end
    rst_n = 1'b1;
    clear_log();
    wait_cycles(8);
    tests++; if ({INR, CLR, DEC, inc_lvl, clr_lvl} !== 5'b00000) begin fails++; $display("FAIL post_reset_outs got %b want 00000", {INR, CLR, DEC, inc_lvl, clr_lvl}); end
    tests++; if (inr_q.size() + clr_q.size() + dec_q.size() !== 0) begin fails++; $display("FAIL post_reset_pulses got %0d want 0", inr_q.size() + clr_q.size() + dec_q.size()); end
  endtask

  task automatic test_inc_repeat();
    int t0;
    int exp_t[5];
    @(negedge clk);
    clear_log();
    btn_inc = 1'b1;
    t0 = cyc;
    exp_t = '{t0 + 7, t0 + 23, t0 + 27, t0 + 31, t0 + 35};
    wait_cycles(30);
    btn_inc = 1'b0;
    wait_cycles(40);
    tests++; if (inr_q.size() !== 5) begin fails++; $display("FAIL inc_repeat_count got %0d want 5", inr_q.size()); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= inr_q.size() || inr_q[i] !== exp_t[i]) begin
        fails++;
        $display("FAIL inc_repeat_time[%0d] got %0d want %0d", i, (i < inr_q.size()) ? inr_q[i] - t0 : -1, exp_t[i] - t0);
      end
    end
    tests++; if (clr_q.size() + dec_q.size() !== 0) begin fails++; $display("FAIL inc_repeat_other got %0d want 0", clr_q.size() + dec_q.size()); end
    tests++; if (n_inc_hi !== 30) begin fails++; $display("FAIL inc_lvl_width got %0d want 30", n_inc_hi); end
    tests++; if (inc_lvl !== 1'b0) begin fails++; $display("FAIL inc_lvl_released got %b want 0", inc_lvl); end
  endtask

  task automatic test_clr_bounce();
    int t;
    @(negedge clk);
    clear_log();
    btn_clr = 1'b1; wait_cycles(1);
    btn_clr = 1'b0; wait_cycles(1);
    btn_clr = 1'b1; wait_cycles(2);
    btn_clr = 1'b0; wait_cycles(2);
    btn_clr = 1'b1; wait_cycles(3);
    btn_clr = 1'b0; wait_cycles(3);
    btn_clr = 1'b1;
    t = cyc;
    wait_cycles(20);
    btn_clr = 1'b0;
    wait_cycles(15);
    tests++; if (clr_q.size() !== 1) begin fails++; $display("FAIL clr_count got %0d want 1", clr_q.size()); end
    tests++; if (clr_q.size() < 1 || clr_q[0] !== t + 7) begin fails++; $display("FAIL clr_time got %0d want %0d", (clr_q.size() > 0) ? clr_q[0] - t : -1, 7); end
    tests++; if (n_clr_rise !== 1) begin fails++; $display("FAIL clr_lvl_rises got %0d want 1", n_clr_rise); end
    tests++; if (inr_q.size() + dec_q.size() !== 0) begin fails++; $display("FAIL clr_other got %0d want 0", inr_q.size() + dec_q.size()); end
  endtask

  task automatic test_chord();
    int t;
    @(negedge clk);
    clear_log();
    btn_inc = 1'b1;
    btn_clr = 1'b1;
    t = cyc;
    wait_cycles(40);
    tests++; if (dec_q.size() !== 1) begin fails++; $display("FAIL chord_dec_count got %0d want 1", dec_q.size()); end
    tests++; if (dec_q.size() < 1 || dec_q[0] !== t + 7) begin fails++; $display("FAIL chord_dec_time got %0d want 7", (dec_q.size() > 0) ? dec_q[0] - t : -1); end
    tests++; if (inr_q.size() + clr_q.size() !== 0) begin fails++; $display("FAIL chord_other got %0d want 0", inr_q.size() + clr_q.size()); end
    btn_inc = 1'b0;
    btn_clr = 1'b0;
    wait_cycles(15);
    tests++; if (inr_q.size() + clr_q.size() + dec_q.size() !== 1) begin fails++; $display("FAIL chord_release got %0d want 1", inr_q.size() + clr_q.size() + dec_q.size()); end
  endtask

  task automatic test_repeat_then_clr();
    int t0;
    int exp_t[4];
    @(negedge clk);
    clear_log();
    btn_inc = 1'b1;
    t0 = cyc;
    exp_t = '{t0 + 7, t0 + 23, t0 + 27, t0 + 31};
    wait_cycles(28);
    btn_clr = 1'b1;
    wait_cycles(40);
    // The clear edge lands on the same cycle as the t0+35 repeat; only DEC survives.
    tests++; if (inr_q.size() !== 4) begin fails++; $display("FAIL rpt_clr_inr_count got %0d want 4", inr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= inr_q.size() || inr_q[i] !== exp_t[i]) begin
        fails++;
        $display("FAIL rpt_clr_inr_time[%0d] got %0d want %0d", i, (i < inr_q.size()) ? inr_q[i] - t0 : -1, exp_t[i] - t0);
      end
    end
    tests++; if (dec_q.size() !== 1 || dec_q[0] !== t0 + 35) begin fails++; $display("FAIL rpt_clr_dec got n=%0d t=%0d want n=1 t=35", dec_q.size(), (dec_q.size() > 0) ? dec_q[0] - t0 : -1); end
    tests++; if (clr_q.size() !== 0) begin fails++; $display("FAIL rpt_clr_clr got %0d want 0", clr_q.size()); end
    btn_clr = 1'b0;
    btn_inc = 1'b0;
    wait_cycles(15);
    tests++; if (inr_q.size() + clr_q.size() + dec_q.size() !== 5) begin fails++; $display("FAIL rpt_clr_release got %0d want 5", inr_q.size() + clr_q.size() + dec_q.size()); end
  endtask

  task automatic test_reset_mid_repeat();
    int t1;
    @(negedge clk);
    clear_log();
    btn_inc = 1'b1;
    wait_cycles(31);
    tests++; if (INR !== 1'b1) begin fails++; $display("FAIL mid_rpt_pulse got %b want 1", INR); end
    rst_n = 1'b0;
    #1;
    tests++; if ({INR, CLR, DEC, inc_lvl, clr_lvl} !== 5'b00000) begin fails++; $display("FAIL async_reset_outs got %b want 00000", {INR, CLR, DEC, inc_lvl, clr_lvl}); end
    wait_cycles(3);
    rst_n = 1'b1;
    clear_log();
    wait_cycles(40);
    tests++; if (inr_q.size() + clr_q.size() + dec_q.size() !== 0) begin fails++; $display("FAIL held_after_reset got %0d want 0", inr_q.size() + clr_q.size() + dec_q.size()); end
    tests++; if (inc_lvl !== 1'b1) begin fails++; $display("FAIL held_lvl_after_reset got %b want 1", inc_lvl); end
    btn_inc = 1'b0;
    wait_cycles(12);
    btn_inc = 1'b1;
    t1 = cyc;
    wait_cycles(10);
    btn_inc = 1'b0;
    wait_cycles(15);
    tests++; if (inr_q.size() !== 1 || inr_q[0] !== t1 + 7) begin fails++; $display("FAIL fresh_press got n=%0d t=%0d want n=1 t=7", inr_q.size(), (inr_q.size() > 0) ? inr_q[0] - t1 : -1); end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    clear_log();
    for (int i = 0; i < 10; i++) begin
      btn_inc = 1'b1;
      wait_cycles(2);
      btn_inc = 1'b0;
      wait_cycles(8);
    end
    wait_cycles(10);
    tests++; if (n_inc_hi !== 0) begin fails++; $display("FAIL glitch_lvl got %0d high cycles want 0", n_inc_hi); end
    tests++; if (inr_q.size() + clr_q.size() + dec_q.size() !== 0) begin fails++; $display("FAIL glitch_pulses got %0d want 0", inr_q.size() + clr_q.size() + dec_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    excl_err     = 0;
    clr_lvl_prev = 1'b0;
    test_reset();
    test_inc_repeat();
    test_clr_bounce();
    test_chord();
    test_repeat_then_clr();
    test_reset_mid_repeat();
    test_glitch();
    tests++; if (excl_err !== 0) begin fails++; $display("FAIL exclusive_cmds got %0d overlaps want 0", excl_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
